// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the iterative divider. Contains the
//               control state encoding, the signed/unsigned mode constants
//               and a width-generic two's-complement absolute value helper.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic DIV_SIGNED   = 1'b1;
    localparam logic DIV_UNSIGNED = 1'b0;

    // Magnitude of a w-bit two's-complement value held zero-extended in v.
    // The result is valid in the low w bits; the most negative value maps
    // to 2**(w-1), which is the correct unsigned magnitude.
    function automatic logic [63:0] abs_w(input logic [63:0] v, input int unsigned w);
        logic [63:0] r;
        r = v;
        if (v[w-1]) begin
            r = ~v + 64'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_clz.sv
`default_nettype none
// ============================================================================
// Module      : div_clz
// Description : Combinational leading-zero counter built as a binary tree.
//               The input is padded on the LSB side with ones up to a power
//               of two so padding never adds to the count; an all-zero input
//               returns WIDTH.
// Ports       : data_i  [WIDTH]  value to examine
//               clz_o   [CNT_W]  number of leading zeros (0..WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module div_clz #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] clz_o
);

    localparam int c_LVLS = $clog2(WIDTH);
    localparam int c_P    = 1 << c_LVLS;
    localparam int c_CW   = c_LVLS + 1;

    logic [c_P-1:0] w_pad;

    generate
        if (c_P == WIDTH) begin : g_no_pad
            assign w_pad = data_i;
        end else begin : g_pad
            assign w_pad = {data_i, {(c_P - WIDTH){1'b1}}};
        end
    endgenerate

    // Node i of a level covers a contiguous run of bits, node 0 being the
    // most significant. Each node holds its leading-zero count; a node is
    // all-zero when its count equals its size. Levels are folded in place:
    // parent i only reads children 2i and 2i+1, which are never overwritten
    // before being read.
    logic [c_CW-1:0] w_cnt [c_P];

    always_comb begin
        for (int i = 0; i < c_P; i++) begin
            w_cnt[i] = c_CW'(~w_pad[c_P-1-i]);
        end
        for (int l = 0; l < c_LVLS; l++) begin
            for (int i = 0; i < (c_P >> (l + 1)); i++) begin
                if (w_cnt[2*i] == c_CW'(1 << l)) begin
                    w_cnt[i] = c_CW'(1 << l) + w_cnt[2*i+1];
                end else begin
                    w_cnt[i] = w_cnt[2*i];
                end
            end
        end
    end

    assign clz_o = CNT_W'(w_cnt[0]);

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative radix-2 restoring divider for the EX stage.
//               One shift/subtract step per clock; signed operands are
//               divided as magnitudes and fixed up on the final step.
//               Optional early-out (macro DIV_ITER_EARLY_OUT_EN) skips the
//               leading zeros of the dividend magnitude.
// Ports       : clk, rst        clock, synchronous active-high reset
//               signed_div_i    1 = signed, 0 = unsigned
//               opdata1_i       dividend   [WIDTH]
//               opdata2_i       divisor    [WIDTH]
//               start_i         request, held until ready_o
//               annul_i         cancel in-flight operation
//               result_o        {remainder, quotient} [2*WIDTH]
//               ready_o         result valid
//               busy_o          operation in progress
//               div_zero_o      last completed operation had divisor 0
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;
    logic               r_busy;
    logic               r_div_zero;

    // ------------------------------------------------------------------
    // Operand preparation at the capture edge
    // ------------------------------------------------------------------
    logic               w_signed_req;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_dvd_load;
    logic [CNT_W-1:0]   w_cnt_load;

    assign w_signed_req = (signed_div_i == DIV_SIGNED);
    assign w_mag_a = w_signed_req ? WIDTH'(abs_w(64'(opdata1_i), WIDTH)) : opdata1_i;
    assign w_mag_b = w_signed_req ? WIDTH'(abs_w(64'(opdata2_i), WIDTH)) : opdata2_i;

`ifdef DIV_ITER_EARLY_OUT_EN
    logic [CNT_W-1:0] w_lz;

    div_clz #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_clz (
        .data_i (w_mag_a),
        .clz_o  (w_lz)
    );

    // Leading zeros of the dividend would only shift zero quotient bits in,
    // so they are skipped. A zero dividend still runs one step.
    assign w_dvd_load = w_mag_a << w_lz;
    assign w_cnt_load = (w_lz == c_CNT_FULL) ? c_CNT_ONE : (c_CNT_FULL - w_lz);
`else
    assign w_dvd_load = w_mag_a;
    assign w_cnt_load = c_CNT_FULL;
`endif

    // ------------------------------------------------------------------
    // One restoring step: shift {rem, dvd} left, trial-subtract divisor.
    // Quotient bits enter the dividend register from the LSB side.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_unused_diff_msb;

    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign {w_borrow, w_diff} = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    // On a successful subtract the difference is below the divisor, so its
    // top bit is always zero.
    assign w_unused_diff_msb = w_diff[WIDTH];
    assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], ~w_borrow};

    // Quotient sign is the XOR of operand signs; remainder follows the
    // dividend. MIN / -1 wraps back to MIN naturally.
    assign w_quo_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = (r_signed && r_sign_a) ? -w_rem_nxt : w_rem_nxt;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_signed   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        r_busy <= 1'b1;
                        if (opdata2_i == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_state  <= BUSY;
                            r_signed <= w_signed_req;
                            r_sign_a <= opdata1_i[WIDTH-1];
                            r_sign_b <= opdata2_i[WIDTH-1];
                            r_rem    <= '0;
                            r_dvd    <= w_dvd_load;
                            r_dvs    <= w_mag_b;
                            r_cnt    <= w_cnt_load;
                        end
                    end
                end
                ZERO: begin
                    r_busy <= 1'b0;
                    if (annul_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_state    <= DONE;
                        r_result   <= '0;
                        r_ready    <= 1'b1;
                        r_div_zero <= 1'b1;
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quo_nxt;
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (r_cnt == c_CNT_ONE) begin
                            r_state    <= DONE;
                            r_result   <= {w_rem_fix, w_quo_fix};
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // A low cycle on start_i is required before a restart.
                    if (!start_i || annul_i) begin
                        r_state <= IDLE;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign busy_o     = r_busy;
    assign div_zero_o = r_div_zero;

endmodule
`default_nettype wire

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised iterative radix-2 divider serving the EX stage of the 5-stage MIPS pipeline; successor to the fixed 32-bit `div` unit.
- Adds WIDTH generalisation, an explicit divide-by-zero flag and busy indication.
- Optional early-out latency reduction.
- EX holds `start_i` while stalled; HI receives the remainder and LO receives the quotient.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; held high by EX until `ready_o` is seen
- annul_i  in  1  cancel in-flight operation (pipeline flush)
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid
- busy_o  out  1  operation in progress (IDLE excluded)
- div_zero_o  out  1  last completed operation had divisor 0

Behaviour:
- Reset: one clock with `rst`=1. State goes to IDLE; `result_o`=0, `ready_o`=0, `busy_o`=0, `div_zero_o`=0; counter = 0. Reset mid-operation discards all work.
- States are IDLE, ZERO, BUSY, DONE.
- IDLE:
  - `start_i`=1, `annul_i`=0 and `opdata2_i`=0 → ZERO.
  - `start_i`=1, `annul_i`=0 and `opdata2_i`≠0 → BUSY. On this capture edge the unit latches operand signs, absolute values (signed mode only), the `signed_div_i` mode and loads the counter.
  - Otherwise stay in IDLE.
- ZERO: next edge → DONE with `result_o`=0 and `div_zero_o`=1.
- BUSY:
  - One restoring shift/subtract step per cycle on {partial remainder, dividend}; subtraction uses a WIDTH+1-bit adder, borrow selects the quotient bit.
  - After WIDTH steps the edge that performs the last step also applies sign fix-up, writes `result_o` and enters DONE.
  - Fix-up: quotient negated if sign(a) XOR sign(b); remainder negated if sign(a). Applies only in signed mode.
  - MIN / -1 yields quotient = MIN (two's-complement wrap), remainder 0; no flag.
- Latency without the early-out feature: `ready_o` rises WIDTH+1 rising edges after `start_i` is first sampled. For WIDTH=32 that is 33 edges.
- DONE:
  - `ready_o`=1 and `result_o` is stable.
  - `start_i`=0 → IDLE with `ready_o`=0 on the next edge.
  - `start_i` held high → remain in DONE. No restart without a low cycle.
- Annul: `annul_i`=1 in ZERO or BUSY → IDLE on the next edge. `result_o` and `div_zero_o` retain their previous values and `ready_o` stays 0. In DONE, `annul_i` behaves like `start_i`=0. `annul_i` has priority over `start_i`.
- `busy_o`=1 in ZERO and BUSY.
- `div_zero_o` is updated only on entry to DONE and cleared on a completed non-zero-divisor operation.
- Operand inputs are don't-care after the capture edge.

Optional Feature:
- Macro: DIV_ITER_EARLY_OUT_EN.
- When defined:
  - On the capture edge, count leading zeros n of |dividend| via div_clz.
  - Pre-shift the dividend left by n and load the counter with max(1, WIDTH-n).
  - Latency becomes 1 + max(1, WIDTH-n) edges; a dividend of 0 gives 2 edges with result 0.
- When undefined: fixed WIDTH iterations; div_clz is not instantiated.
- Results are bit-identical in both builds.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, ZERO, BUSY, DONE};
  - localparams DIV_SIGNED=1, DIV_UNSIGNED=0;
  - function abs_w (two's-complement absolute value, WIDTH generic).
- One natural sub-module: div_clz, a parametrised leading-zero counter (WIDTH in, CNT_W out, combinational tree). It is used only under DIV_ITER_EARLY_OUT_EN.

Test Plan:
- Unsigned, WIDTH=32: 100 / 7 → `result_o` = {32'd2, 32'd14}, `ready_o` after 33 edges; `div_zero_o`=0.
- Signed: -7 / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divisor 0 (dividend 0x1234) → `ready_o` after 2 edges, `result_o`=0, `div_zero_o`=1. A following 9/3 → {0, 3} with `div_zero_o`=0.
- Start 100/7, assert `annul_i` at step 10 → IDLE next edge, `ready_o` never rises, `busy_o`=0. An immediate new start 50/5 → {0, 10} with full latency.
- Hold `start_i` 5 cycles in DONE → `ready_o` and `result_o` stable. Drop `start_i` → `ready_o`=0 next edge. Assert `rst` mid-BUSY → all outputs 0 next edge.
- With DIV_ITER_EARLY_OUT_EN, unsigned 5 / 2 (n=29) → {1, 2} after 4 edges. Dividend 0 → 2 edges. Randomised 10k operands in both builds match a reference model; repeat at WIDTH=8.
